// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for rggen bus responders.
// Status codes returned on the external register bus.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_external_ram_array.sv
// Flop-based word array with a byte-enable write port and a combinational read port.
// Indices at or beyond WORDS read as zero and never write.
module rggen_external_ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [INDEX_WIDTH-1:0]  write_index_i,
  input  logic [DATA_WIDTH/8-1:0] strobe_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  input  logic [INDEX_WIDTH-1:0]  read_index_i,
  output logic [DATA_WIDTH-1:0]   read_data_o
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Aw = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic                  write_in_range;
  logic                  read_in_range;

  assign write_in_range = 32'(write_index_i) < WORDS;
  assign read_in_range  = 32'(read_index_i) < WORDS;
  assign read_data_o    = read_in_range ? mem_q[read_index_i[Aw-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= INITIAL_VALUE;
      end
    end else if (we_i && write_in_range) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (strobe_i[b]) begin
          mem_q[write_index_i[Aw-1:0]][8*b +: 8] <= write_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/rggen_external_ram_slave.sv
// Word-addressed RAM responder for the external register bus with a fixed wait-state count.
// Each command gets a one-cycle registered response; an OKAY write commits in the response cycle.
module rggen_external_ram_slave
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDRESS_WIDTH = 7,
  parameter int unsigned WORDS = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic                     i_write,
  input  logic                     i_read,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH/8-1:0]  i_strobe,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  output logic                     o_ready,
  output rggen_status              o_status,
  output logic [DATA_WIDTH-1:0]    o_read_data
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Lsb = $clog2(Bytes);
  localparam int unsigned Iw = ADDRESS_WIDTH - Lsb;

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e                state_q;
  logic [3:0]            count_q;
  logic [Iw-1:0]         index_q;
  logic                  write_q;
  logic                  read_q;
  logic [Bytes-1:0]      strobe_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  rggen_status           status_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [Iw-1:0]         idx_src;
  logic                  wr_src;
  logic                  rd_src;
  logic                  cmd_ok;
  logic                  enter_respond;
  logic                  array_we;
  logic [DATA_WIDTH-1:0] array_rdata;

  // With zero wait states RESPOND is entered on the capture edge, so decode the live command.
  always_comb begin
    idx_src = index_q;
    wr_src  = write_q;
    rd_src  = read_q;
    if (state_q == StIdle) begin
      idx_src = i_address[ADDRESS_WIDTH-1:Lsb];
      wr_src  = i_write;
      rd_src  = i_read;
    end
  end

  assign cmd_ok        = (32'(idx_src) < WORDS) && (wr_src ^ rd_src);
  assign enter_respond = i_valid &&
                         (((state_q == StIdle) && (WAIT_CYCLES == 0)) ||
                          ((state_q == StWait) && (count_q == 4'd1)));
  assign array_we      = (state_q == StRespond) && (status_q == RGGEN_OKAY) && write_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      index_q  <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      status_q <= RGGEN_OKAY;
      rdata_q  <= '0;
    end else begin
      ready_q  <= 1'b0;
      status_q <= RGGEN_OKAY;
      rdata_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            index_q  <= i_address[ADDRESS_WIDTH-1:Lsb];
            write_q  <= i_write;
            read_q   <= i_read;
            strobe_q <= i_strobe;
            wdata_q  <= i_write_data;
            count_q  <= 4'(WAIT_CYCLES);
            state_q  <= (WAIT_CYCLES == 0) ? StRespond : StWait;
          end
        end
        StWait: begin
          if (!i_valid) begin
            state_q <= StIdle;
          end else begin
            count_q <= count_q - 4'd1;
            if (count_q == 4'd1) begin
              state_q <= StRespond;
            end
          end
        end
        StRespond: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
      if (enter_respond) begin
        ready_q  <= 1'b1;
        status_q <= cmd_ok ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
        rdata_q  <= (cmd_ok && rd_src) ? array_rdata : '0;
      end
    end
  end

  rggen_external_ram_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .WORDS         (WORDS),
    .INDEX_WIDTH   (Iw),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_array (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .we_i          (array_we),
    .write_index_i (index_q),
    .strobe_i      (strobe_q),
    .write_data_i  (wdata_q),
    .read_index_i  (idx_src),
    .read_data_o   (array_rdata)
  );

  assign o_ready     = ready_q;
  assign o_status    = status_q;
  assign o_read_data = rdata_q;

endmodule

// File: tb/tb_rggen_external_ram_slave.sv
// Directed bench for rggen_external_ram_slave: a 2-wait/16-word instance and a 0-wait instance.
// Expected responses are queued when a command is driven and popped on each o_ready pulse.
module tb_rggen_external_ram_slave;

  localparam logic [31:0] InitA = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, write, read, sel;
  logic [6:0]  addr;
  logic [3:0]  strobe;
  logic [31:0] wdata;

  logic        a_valid, b_valid, a_ready, b_ready, ready;
  logic [1:0]  a_status, b_status, status;
  logic [31:0] a_rdata, b_rdata, rdata;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] d;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;
  assign ready   = sel ? b_ready : a_ready;
  assign status  = sel ? b_status : a_status;
  assign rdata   = sel ? b_rdata : a_rdata;

  rggen_external_ram_slave #(
    .WORDS         (16),
    .WAIT_CYCLES   (2),
    .INITIAL_VALUE (InitA)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (a_valid),
    .i_write      (write),
    .i_read       (read),
    .i_address    (addr),
    .i_strobe     (strobe),
    .i_write_data (wdata),
    .o_ready      (a_ready),
    .o_status     (a_status),
    .o_read_data  (a_rdata)
  );

  rggen_external_ram_slave #(
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (b_valid),
    .i_write      (write),
    .i_read       (read),
    .i_address    (addr),
    .i_strobe     (strobe),
    .i_write_data (wdata),
    .o_ready      (b_ready),
    .o_status     (b_status),
    .o_read_data  (b_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command, wait for its response and compare against the queued expectation.
  task automatic cmd(input string tag, input logic w, input logic r, input logic [6:0] a,
                     input logic [3:0] s, input logic [31:0] d, input logic [1:0] est,
                     input logic [31:0] ed, input int lat);
    resp_t e;
    int    n;
    bit    seen;
    exp_q.push_back('{st: est, d: ed});
    @(posedge clk); #1;
    valid = 1'b1; write = w; read = r; addr = a; strobe = s; wdata = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
      else n++;
    end
    check({tag, " seen"}, 64'(seen), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (seen) begin
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " status"}, 64'(status), 64'(e.st));
      check({tag, " data"}, 64'(rdata), 64'(e.d));
    end
    @(posedge clk); #1;
    valid = 1'b0; write = 1'b0; read = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {29'd0, ready, status, rdata}, 64'd0);
  endtask

  initial begin
    logic [5:0] pattern;
    int         pulses;

    rst_n = 1'b0; valid = 1'b0; write = 1'b0; read = 1'b0; sel = 1'b0;
    addr = '0; strobe = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {29'd0, a_ready, a_status, a_rdata}, 64'd0);
    check("reset_b", {29'd0, b_ready, b_status, b_rdata}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cmd("wr04", 1, 0, 7'h04, 4'hF, 32'hDEAD_BEEF, 2'b00, 32'h0, 3);
    cmd("rd04", 0, 1, 7'h04, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 3);
    cmd("rd07_lowbits", 0, 1, 7'h07, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 3);
    cmd("rd00_init", 0, 1, 7'h00, 4'hF, 32'h0, 2'b00, InitA, 3);

    cmd("wr08_full", 1, 0, 7'h08, 4'hF, 32'h1122_3344, 2'b00, 32'h0, 3);
    cmd("wr08_strb", 1, 0, 7'h08, 4'b0101, 32'hAABB_CCDD, 2'b00, 32'h0, 3);
    cmd("rd08_strb", 0, 1, 7'h08, 4'hF, 32'h0, 2'b00, 32'h11BB_33DD, 3);
    cmd("wr08_nostrb", 1, 0, 7'h08, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'h0, 3);
    cmd("rd08_nostrb", 0, 1, 7'h08, 4'hF, 32'h0, 2'b00, 32'h11BB_33DD, 3);

    cmd("wr40_oor", 1, 0, 7'h40, 4'hF, 32'h5555_5555, 2'b10, 32'h0, 3);
    cmd("rd40_oor", 0, 1, 7'h40, 4'hF, 32'h0, 2'b10, 32'h0, 3);
    cmd("rd7c_oor", 0, 1, 7'h7C, 4'hF, 32'h0, 2'b10, 32'h0, 3);
    cmd("rd00_after_oor", 0, 1, 7'h00, 4'hF, 32'h0, 2'b00, InitA, 3);

    cmd("wr10_both", 1, 1, 7'h10, 4'hF, 32'h7777_7777, 2'b10, 32'h0, 3);
    cmd("rd10_after_both", 0, 1, 7'h10, 4'hF, 32'h0, 2'b00, InitA, 3);
    cmd("none10", 0, 0, 7'h10, 4'hF, 32'h0, 2'b10, 32'h0, 3);

    // Abort in WAIT: drop valid one cycle after acceptance.
    cmd("wr0c", 1, 0, 7'h0C, 4'hF, 32'h0C0C_0C0C, 2'b00, 32'h0, 3);
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b1; addr = 7'h0C; strobe = 4'hF; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    valid = 1'b0; write = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("abort_no_ready", 64'(pulses), 64'd0);
    cmd("rd0c_after_abort", 0, 1, 7'h0C, 4'hF, 32'h0, 2'b00, 32'h0C0C_0C0C, 3);

    // Reset in WAIT.
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b1; addr = 7'h0C; strobe = 4'hF; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst_n = 1'b0; valid = 1'b0; write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_wait_outputs", {29'd0, ready, status, rdata}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("reset_no_ready", 64'(pulses), 64'd0);
    cmd("rd0c_after_reset", 0, 1, 7'h0C, 4'hF, 32'h0, 2'b00, InitA, 3);
    cmd("rd04_after_reset", 0, 1, 7'h04, 4'hF, 32'h0, 2'b00, InitA, 3);

    // Zero-wait instance.
    sel = 1'b1;
    cmd("b_wr08", 1, 0, 7'h08, 4'hF, 32'h0000_BEEF, 2'b00, 32'h0, 1);
    cmd("b_rd08", 0, 1, 7'h08, 4'hF, 32'h0, 2'b00, 32'h0000_BEEF, 1);
    cmd("b_rd10_init", 0, 1, 7'h10, 4'hF, 32'h0, 2'b00, 32'h0, 1);

    // Held valid: three reads back to back.
    repeat (3) exp_q.push_back('{st: 2'b00, d: 32'h0000_BEEF});
    @(posedge clk); #1;
    valid = 1'b1; read = 1'b1; addr = 7'h08;
    pattern = '0;
    for (int c = 0; c < 6; c++) begin
      resp_t e;
      @(negedge clk);
      pattern[c] = ready;
      if (ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("b_b2b_status", 64'(status), 64'(e.st));
        check("b_b2b_data", 64'(rdata), 64'(e.d));
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; read = 1'b0;
    check("b_b2b_pattern", 64'(pattern), 64'(6'b101010));
    check("b_b2b_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
